// File: rtl/mdr_seq_multiplier.sv
// mdr_seq_multiplier: iterative unsigned shift-add multiplier paced by the down-counter's overflow
module mdr_seq_multiplier #(
    parameter int DW = 16,
    parameter int IW = $clog2(DW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [DW-1:0]   i_multiplicand,
    input  logic [DW-1:0]   i_multiplier,
    output logic            o_count_en,
    input  logic            i_count_ovf,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [2*DW-1:0] o_product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state_q;
    logic [DW-1:0]   m_q;
    logic [2*DW-1:0] p_q, p_d, prod_q;
    logic [IW-1:0]   idx_q;
    logic            err_q;
    logic [DW:0]     sum;
    logic            last;
    // one shift-add step: add M to the upper half when the current multiplier bit is set, then shift right with carry
    assign sum  = {1'b0, p_q[2*DW-1:DW]} + (p_q[0] ? {1'b0, m_q} : '0);
    assign p_d  = {sum, p_q[DW-1:1]};
    assign last = idx_q == IW'(DW - 1);
    // sequencer: capture operands on start, iterate until the counter overflow, publish result for one DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_q     <= '0;
            prod_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    m_q     <= i_multiplicand;
                    p_q     <= {{DW{1'b0}}, i_multiplier};
                    idx_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= RUN;
                end
                RUN: if (i_count_ovf && !last) begin
                    err_q   <= 1'b1;
                    prod_q  <= '0;
                    state_q <= DONE;
                end else begin
                    p_q   <= p_d;
                    idx_q <= idx_q + 1'b1;
                    if (last) begin
                        err_q   <= !i_count_ovf;
                        prod_q  <= i_count_ovf ? p_d : '0;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_count_en = state_q == RUN;
    assign o_busy     = state_q != IDLE;
    assign o_done     = state_q == DONE;
    assign o_err      = err_q;
    assign o_product  = prod_q;
endmodule

// File: tb/tb_mdr_seq_multiplier.sv
// tb_mdr_seq_multiplier: scoreboard bench with a behavioural down-counter / fault stub driving the overflow input
module tb_mdr_seq_multiplier;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [DW-1:0] mcand = '0, mplier = '0;
    logic en, ovf, busy, done, err;
    logic [2*DW-1:0] prod;
    int checks = 0;
    int errors = 0;
    int mode = 0;
    logic [4:0] cnt = 5'd15;
    int rc = 0;
    logic [2*DW:0] sb[$];
    logic [2*DW:0] exp_v;
    int en_cnt, done_cyc;

    mdr_seq_multiplier #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_multiplicand(mcand), .i_multiplier(mplier),
        .o_count_en(en), .i_count_ovf(ovf), .o_busy(busy), .o_done(done), .o_err(err), .o_product(prod)
    );

    always #5 clk = ~clk;

    // counter model (LIMIT=16) plus fault stubs: mode 1 overflows in RUN cycle 5, mode 2 never overflows
    always @(posedge clk) begin
        cnt <= en ? cnt - 5'd1 : 5'd15;
        rc  <= en ? rc + 1 : 0;
    end
    assign ovf = mode == 0 ? (cnt == 5'd0) : mode == 1 ? (en && rc == 4) : 1'b0;

    // scoreboard: every done pulse pops one expected {err, product}
    always @(negedge clk) begin
        if (rst && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done err=%0b product=%h", err, prod);
            end else begin
                exp_v = sb.pop_front();
                if ({err, prod} !== exp_v) begin
                    errors++;
                    $display("FAIL result got err=%0b product=%h expected err=%0b product=%h",
                             err, prod, exp_v[2*DW], exp_v[2*DW-1:0]);
                end
            end
        end
    end

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2*DW-1:0] ep,
                          input logic ee, output int n_en, output int d_cyc);
        @(negedge clk);
        mcand = a;
        mplier = b;
        start = 1'b1;
        sb.push_back({ee, ep});
        n_en = 0;
        d_cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (en) n_en++;
            if (done) begin
                d_cyc = k;
                break;
            end
        end
        checks++;
        if (d_cyc == 0) begin
            errors++;
            $display("FAIL timeout no done for a=%h b=%h", a, b);
        end
    endtask

    function automatic logic [2*DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({en, busy, done, err, prod} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%0b busy=%0b done=%0b err=%0b product=%h expected all 0",
                     en, busy, done, err, prod);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_op(16'd3, 16'd5, 32'h0000000F, 1'b0, en_cnt, done_cyc);
        checks++;
        if (en_cnt !== 16) begin
            errors++;
            $display("FAIL basic_en_cycles got %0d expected 16", en_cnt);
        end
        checks++;
        if (done_cyc !== 17) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 17", done_cyc);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_in_done got %0b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, err, prod} !== {1'b0, 1'b0, 1'b0, 32'h0000000F}) begin
            errors++;
            $display("FAIL basic_hold got done=%0b busy=%0b err=%0b product=%h expected 0 0 0 0000000f",
                     done, busy, err, prod);
        end
    endtask

    task automatic test_patterns();
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, en_cnt, done_cyc);
        run_op(16'h0000, 16'h1234, 32'h00000000, 1'b0, en_cnt, done_cyc);
        run_op(16'h8000, 16'h0002, 32'h00010000, 1'b0, en_cnt, done_cyc);
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] a, b;
            a = DW'($urandom);
            b = DW'($urandom);
            run_op(a, b, mul(a, b), 1'b0, en_cnt, done_cyc);
        end
    endtask

    task automatic test_start_held();
        int nd = 0;
        int d1 = 0;
        int d2 = 0;
        @(negedge clk);
        mcand = 16'd7;
        mplier = 16'd11;
        start = 1'b1;
        sb.push_back({1'b0, 32'd77});
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 3) begin
                mcand = 16'h00FF;
                mplier = 16'h0101;
                sb.push_back({1'b0, 32'h0000FFFF});
            end
            if (k == 19) start = 1'b0;
            if (done) begin
                nd++;
                if (nd == 1) d1 = k;
                else d2 = k;
            end
        end
        checks++;
        if (nd !== 2 || d1 !== 17 || d2 !== 35) begin
            errors++;
            $display("FAIL start_held got dones=%0d at %0d,%0d expected 2 at 17,35", nd, d1, d2);
        end
    endtask

    task automatic test_early_ovf();
        mode = 1;
        run_op(16'h1234, 16'h5678, 32'h0, 1'b1, en_cnt, done_cyc);
        checks++;
        if (en_cnt !== 5 || done_cyc !== 6) begin
            errors++;
            $display("FAIL early_ovf_timing got en=%0d done=%0d expected 5 6", en_cnt, done_cyc);
        end
        mode = 0;
        run_op(16'h1234, 16'h0010, 32'h00012340, 1'b0, en_cnt, done_cyc);
    endtask

    task automatic test_no_ovf();
        mode = 2;
        run_op(16'd100, 16'd200, 32'h0, 1'b1, en_cnt, done_cyc);
        checks++;
        if (en_cnt !== 16 || done_cyc !== 17) begin
            errors++;
            $display("FAIL no_ovf_timing got en=%0d done=%0d expected 16 17", en_cnt, done_cyc);
        end
        mode = 0;
        run_op(16'd100, 16'd200, 32'd20000, 1'b0, en_cnt, done_cyc);
    endtask

    task automatic test_mid_reset();
        int nd = 0;
        @(negedge clk);
        mcand = 16'd50;
        mplier = 16'd60;
        start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({en, busy, done, err, prod} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got en=%0b busy=%0b done=%0b err=%0b product=%h expected all 0",
                     en, busy, done, err, prod);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL mid_reset_idle got %0d busy/done cycles expected 0", nd);
        end
        run_op(16'd7, 16'd9, 32'd63, 1'b0, en_cnt, done_cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_start_held();
        test_early_ovf();
        test_no_ovf();
        test_mid_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdr_seq_multiplier.md
Name: mdr_seq_multiplier

Overview:
- Iterative unsigned shift-add multiplier for the MDR arithmetic subsystem.
- Sits directly upstream of the down-counter block and owns its i_enable input; consumes the counter's o_ovf to end each operation.
- Processes one multiplier bit per clock with a start/busy/done handshake to the MDR top-level control.

Parameters:
DW, 16, operand width. Must equal the companion counter's LIMIT so the counter gives exactly DW enabled cycles.
IW, $clog2(DW), width of the internal shadow iteration index.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
i_start  input  1  start request; sampled only in IDLE
i_multiplicand  input  DW  operand A, captured on accepted start
i_multiplier  input  DW  operand B, captured on accepted start
o_count_en  output  1  drives counter i_enable; high exactly while in RUN
i_count_ovf  input  1  counter o_ovf (counter value == 0)
o_busy  output  1  high in RUN and DONE
o_done  output  1  one-cycle pulse in DONE
o_err  output  1  sequencing error flag; valid with o_done, held until next accepted start
o_product  output  2*DW  result; valid from o_done, held until next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0, internal registers cleared. Reset mid-operation aborts with no o_done.
- States: IDLE, RUN, DONE. o_count_en, o_busy and o_done decode from state only (Moore). No combinational path from inputs to outputs.
- IDLE:
  - o_count_en=0, so the counter holds LIMIT-1.
  - i_start=1: capture M=i_multiplicand, P={DW'0, i_multiplier}, idx=0, clear o_err; go to RUN.
  - i_count_ovf is ignored in IDLE.
- RUN iteration, one per cycle:
  - sum = P[2DW-1:DW] + (P[0] ? M : 0), computed at DW+1 bits.
  - P <= {sum, P[DW-1:1]} (logical right shift, carry enters the MSB); idx <= idx+1.
  - Arithmetic is unsigned; no overflow is possible within 2*DW bits.
- RUN exit:
  - i_count_ovf=1 and idx==DW-1: perform the iteration, go to DONE, o_err=0.
  - i_count_ovf=1 and idx<DW-1 (early ovf): go to DONE with o_err=1; the iteration is not applied.
  - idx==DW-1 and i_count_ovf=0 (missing ovf): perform the iteration, go to DONE with o_err=1.
- DONE: lasts one cycle.
  - o_done=1; o_product=P, or 0 when o_err=1.
  - o_count_en=0, so the counter reloads. Next state is IDLE.
  - i_start in DONE is ignored.
- Latency: start accepted at edge 0 → RUN for cycles 1..DW → o_done high in cycle DW+1. Throughput is one operation per DW+2 cycles.
- i_start while busy: ignored; operands are not re-captured.
- Operand inputs may change after the start edge without affecting the result.
- o_product and o_err hold after DONE until the next accepted start, where o_err clears and o_product holds until DONE.

Test Plan:
- DW=16 with the companion counter instance (LIMIT=16): A=3, B=5, pulse start → o_count_en high for exactly 16 cycles, o_done pulse 17 cycles after the start edge, o_product=0x0000000F, o_err=0.
- A=0xFFFF, B=0xFFFF → o_product=0xFFFE0001. Then A=0, B=0x1234 → o_product=0. Then A=0x8000, B=0x0002 → o_product=0x00010000.
- Start held high through RUN and DONE, with operands changed mid-run → exactly one o_done per IDLE acceptance; first result unaffected by the changed operands.
- Counter replaced by a stub asserting i_count_ovf at RUN cycle 5 → o_done with o_err=1 and o_product=0. Next clean operation clears o_err and returns a correct result.
- Stub never asserts ovf → o_done after 16 RUN cycles with o_err=1.
- rst pulsed low in RUN cycle 8 → all outputs 0 immediately, state IDLE, no o_done. A subsequent 7×9 produces 63.
